spi_m: RTL and testbench

- SPI master (mode 0: CPOL=0, CPHA=0), the initiator side for the team's `spi_S` slave.
- Serialises one DATA_W-bit word on mosi and, in the same transaction, captures one word from miso.
- Drives sclk and cs_n. Default bit order is LSB-first, matching the slave's right-shift datapath.
- Sits between a local controller (start/busy/done handshake) and the SPI pins.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_m_if.sv | 29 ++
 rtl/spi_m_tick.sv | 40 ++++
 rtl/spi_m.sv | 159 +++++++++++++++
 tb/tb_spi_m.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the spi_m SPI master: FSM state encoding and default sizing.
package spi_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        DONE
    } state_e;

endpackage

// File: rtl/spi_m_if.sv
// Controller handshake and SPI pin bundle for spi_m.
// The master modport is the spi_m side; the slave modport is the controller/pin side.
interface spi_m_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              start;
    logic [DATA_W-1:0] din;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              done;

    modport master (
        input  start, din, miso,
        output sclk, mosi, cs_n, dout, busy, done
    );

    modport slave (
        output start, din, miso,
        input  sclk, mosi, cs_n, dout, busy, done
    );

endinterface

// File: rtl/spi_m_tick.sv
// Loadable down-counter that times one sclk half-period.
// half_done is high in the CLK_DIV-th enabled cycle after load.
module spi_m_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic half_done
);

    localparam int            CW     = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_done = en && (cnt_q == '0);

endmodule

// File: rtl/spi_m.sv
// SPI mode-0 master: one DATA_W-bit full-duplex word per start, LSB-first by default.
// Define SPI_M_MSB_FIRST_EN for MSB-first order; timing is identical in both builds.
module spi_m
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input logic     clk,
    input logic     rst,
    spi_m_if.master bus
);

    localparam int            BW       = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] ALL_BITS = BW'(DATA_W);

    state_e            state_q, state_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] shift_in_q, shift_in_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              tick_load;
    logic              tick_en;
    logic              half_done;
    logic [DATA_W-1:0] captured;
    logic [DATA_W-1:0] shifted;
    logic              mosi_bit;

    // mosi is the outgoing end of shift_out, so clearing shift_out parks mosi at 0.
`ifdef SPI_M_MSB_FIRST_EN
    assign captured = {shift_in_q[DATA_W-2:0], bus.miso};
    assign shifted  = {shift_out_q[DATA_W-2:0], 1'b0};
    assign mosi_bit = shift_out_q[DATA_W-1];
`else
    assign captured = {bus.miso, shift_in_q[DATA_W-1:1]};
    assign shifted  = {1'b0, shift_out_q[DATA_W-1:1]};
    assign mosi_bit = shift_out_q[0];
`endif

    assign tick_en = (state_q != IDLE) && (state_q != DONE);

    spi_m_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (tick_load),
        .en       (tick_en),
        .half_done(half_done)
    );

    always_comb begin
        state_d     = state_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        dout_d      = dout_q;
        tick_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tick_load   = 1'b1;
                    shift_out_d = bus.din;
                    shift_in_d  = '0;
                    bit_cnt_d   = '0;
                    cs_n_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (half_done) begin
                    tick_load  = 1'b1;
                    sclk_d     = 1'b1;
                    shift_in_d = captured;
                    state_d    = SCK_HI;
                end
            end
            SCK_HI: begin
                if (half_done) begin
                    tick_load = 1'b1;
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q != LAST_BIT) begin
                        shift_out_d = shifted;
                    end
                    state_d = SCK_LO;
                end
            end
            SCK_LO: begin
                // After the last bit this low phase is the cs_n hold time before DONE.
                if (half_done) begin
                    if (bit_cnt_q == ALL_BITS) begin
                        done_d  = 1'b1;
                        dout_d  = shift_in_q;
                        state_d = DONE;
                    end else begin
                        tick_load  = 1'b1;
                        sclk_d     = 1'b1;
                        shift_in_d = captured;
                        state_d    = SCK_HI;
                    end
                end
            end
            DONE: begin
                cs_n_d      = 1'b1;
                shift_out_d = '0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_out_q <= '0;
            shift_in_q  <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_bit;
    assign bus.cs_n = cs_n_q;
    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spi_m.sv
// Self-checking bench for spi_m: directed vector table on a CLK_DIV=1 instance,
// plus hand-written sequences on CLK_DIV=1 and CLK_DIV=3 instances.
module tb_spi_m;

    localparam int DW = 8;
`ifdef SPI_M_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] slv;
        logic [7:0] exp_dout;
        logic [7:0] exp_stream;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errs   = 0;
    int   checks = 0;

    spi_m_if #(.DATA_W(DW)) bus_a ();
    spi_m_if #(.DATA_W(DW)) bus_b ();

    spi_m #(.DATA_W(DW), .CLK_DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    spi_m #(.DATA_W(DW), .CLK_DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Slave models: miso presents bit number "rise count"; mosi is logged at each sclk rise.
    logic [7:0] slv_word_a = 8'h00;
    logic [7:0] slv_word_b = 8'h00;
    logic [7:0] mosi_rx_a  = 8'h00;
    logic [7:0] mosi_rx_b  = 8'h00;
    int         rise_a = 0, rise_b = 0;
    int         last_rises_a = 0, last_rises_b = 0;
    bit         glitch_a = 1'b0, glitch_b = 1'b0;

    function automatic logic pick(input logic [7:0] w, input int i);
        if (i < 0 || i > 7) return 1'b0;
        return MSB ? w[7 - i] : w[i];
    endfunction

    assign bus_a.miso = pick(slv_word_a, rise_a);
    assign bus_b.miso = pick(slv_word_b, rise_b);

    always @(posedge bus_a.sclk or posedge bus_a.cs_n) begin
        if (bus_a.cs_n) begin
            last_rises_a = rise_a;
            rise_a = 0;
        end else begin
            if (rise_a < 8) mosi_rx_a[rise_a[2:0]] = bus_a.mosi;
            rise_a++;
        end
    end

    always @(posedge bus_b.sclk or posedge bus_b.cs_n) begin
        if (bus_b.cs_n) begin
            last_rises_b = rise_b;
            rise_b = 0;
        end else begin
            if (rise_b < 8) mosi_rx_b[rise_b[2:0]] = bus_b.mosi;
            rise_b++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (bus_a.cs_n === 1'b1 && bus_a.sclk === 1'b1) glitch_a = 1'b1;
        if (bus_b.cs_n === 1'b1 && bus_b.sclk === 1'b1) glitch_b = 1'b1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word in cycle 0, then drop start and scramble din for the rest of the word.
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] s);
        slv_word_a  = s;
        bus_a.din   = d;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.din   = ~d;
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int first  = -1;
        int pulses = 0;
        applyStimulus(v.din, v.slv);
        for (int n = 1; n <= 25; n++) begin
            if (bus_a.done === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            tick();
        end
        checkOutput($sformatf("vec%0d_done_cycle", idx), first, 18);
        checkOutput($sformatf("vec%0d_done_pulses", idx), pulses, 1);
        checkOutput($sformatf("vec%0d_dout", idx), int'(bus_a.dout), int'(v.exp_dout));
        checkOutput($sformatf("vec%0d_mosi_stream", idx), int'(mosi_rx_a), int'(v.exp_stream));
        checkOutput($sformatf("vec%0d_sclk_rises", idx), last_rises_a, 8);
    endtask

    vec_t vecs[5];

    initial begin
        int first, pulses, d1, d2, cshigh, cs_low, sclk_hi, run, last_run, bad_runs;
        logic prev;

        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{8'h01, 8'h80, 8'h80, (MSB ? 8'h80 : 8'h01)};
        vecs[4] = '{8'hC4, 8'h1E, 8'h1E, (MSB ? 8'h23 : 8'hC4)};

        rst         = 1'b0;
        bus_a.start = 1'b0;
        bus_a.din   = '0;
        bus_b.start = 1'b0;
        bus_b.din   = '0;
        #12;
        checkOutput("reset_cs_n", int'(bus_a.cs_n), 1);
        checkOutput("reset_sclk", int'(bus_a.sclk), 0);
        checkOutput("reset_mosi", int'(bus_a.mosi), 0);
        checkOutput("reset_busy", int'(bus_a.busy), 0);
        checkOutput("reset_done", int'(bus_a.done), 0);
        checkOutput("reset_dout", int'(bus_a.dout), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) runVec(vecs[i], i);

        // CLK_DIV=3 word: every sclk phase is 3 cycles, the trailing low phase runs into DONE.
        $display("[TB] CLK_DIV=3 transfer");
        slv_word_b  = 8'hC3;
        bus_b.din   = 8'h81;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        bus_b.din   = 8'h00;
        first = -1; pulses = 0; cs_low = 0; sclk_hi = 0; run = 0; last_run = 0; bad_runs = 0;
        prev = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (bus_b.done === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (bus_b.cs_n === 1'b0) begin
                cs_low++;
                if (bus_b.sclk === 1'b1) sclk_hi++;
                if (bus_b.sclk === prev) begin
                    run++;
                end else begin
                    if (run != 3) bad_runs++;
                    run  = 1;
                    prev = bus_b.sclk;
                end
                last_run = run;
            end
            tick();
        end
        checkOutput("div3_done_cycle", first, 52);
        checkOutput("div3_done_pulses", pulses, 1);
        checkOutput("div3_cs_low_cycles", cs_low, 52);
        checkOutput("div3_sclk_high_cycles", sclk_hi, 24);
        checkOutput("div3_bad_phase_runs", bad_runs, 0);
        checkOutput("div3_final_low_run", last_run, 4);
        checkOutput("div3_dout", int'(bus_b.dout), 8'hC3);
        checkOutput("div3_mosi_stream", int'(mosi_rx_b), 8'h81);
        checkOutput("div3_sclk_rises", last_rises_b, 8);

        // Starts during a word and in the DONE cycle must be dropped.
        $display("[TB] start pulses while busy");
        applyStimulus(8'h5A, 8'h99);
        first = -1; pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            bus_a.start = (n == 5 || n == 18);
            if (bus_a.done === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (n == 18) checkOutput("busy_in_done_cycle", int'(bus_a.busy), 1);
            if (n == 19) checkOutput("busy_after_done", int'(bus_a.busy), 0);
            tick();
        end
        bus_a.start = 1'b0;
        checkOutput("ignored_start_done_cycle", first, 18);
        checkOutput("ignored_start_pulses", pulses, 1);
        checkOutput("ignored_start_dout", int'(bus_a.dout), 8'h99);

        // Held start: back-to-back words separated by one cs_n-high cycle.
        $display("[TB] start held high");
        slv_word_a  = 8'h66;
        bus_a.din   = 8'h11;
        bus_a.start = 1'b1;
        tick();
        d1 = -1; d2 = -1; pulses = 0; cshigh = 0;
        for (int n = 1; n <= 45; n++) begin
            if (bus_a.done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    d1         = n;
                    bus_a.din  = 8'h22;
                    slv_word_a = 8'h77;
                end else if (pulses == 2) begin
                    d2          = n;
                    bus_a.start = 1'b0;
                end
            end
            if (pulses == 1 && bus_a.cs_n === 1'b1) cshigh++;
            tick();
        end
        bus_a.start = 1'b0;
        checkOutput("held_first_done", d1, 18);
        checkOutput("held_second_done", d2, 37);
        checkOutput("held_done_pulses", pulses, 2);
        checkOutput("held_cs_n_gap", cshigh, 1);
        checkOutput("held_dout", int'(bus_a.dout), 8'h77);
        checkOutput("held_mosi_stream", int'(mosi_rx_a), int'(MSB ? 8'h44 : 8'h22));

        // Asynchronous reset in cycle 9 of a word.
        $display("[TB] reset mid-transfer");
        applyStimulus(8'hF0, 8'h0F);
        pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            if (bus_a.done === 1'b1) pulses++;
            tick();
        end
        checkOutput("abort_busy_before_reset", int'(bus_a.busy), 1);
        rst = 1'b0;
        #1;
        checkOutput("abort_cs_n", int'(bus_a.cs_n), 1);
        checkOutput("abort_sclk", int'(bus_a.sclk), 0);
        checkOutput("abort_busy", int'(bus_a.busy), 0);
        checkOutput("abort_done", int'(bus_a.done), 0);
        checkOutput("abort_dout", int'(bus_a.dout), 0);
        checkOutput("abort_no_done_seen", pulses, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        runVec(vecs[4], 5);

        checkOutput("sclk_low_while_cs_high_a", int'(glitch_a), 0);
        checkOutput("sclk_low_while_cs_high_b", int'(glitch_b), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
